// File: rtl/id_ex_ctrl_seg.sv
// ID/EX segment register with load-use hazard detection and a saturating bubble counter.
// Latency 1 cycle ID->EX; en=0 holds the slot, flush and load-use stall load a zeroed bubble.
module id_ex_ctrl_seg #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_d,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic              jal_d,
  input  logic              jalr_d,
  input  logic              mem_to_reg_d,
  input  logic              load_npc_d,
  input  logic              alu_src1_d,
  input  logic [2:0]        reg_write_d,
  input  logic [3:0]        mem_write_d,
  input  logic [1:0]        reg_read_d,
  input  logic [2:0]        branch_type_d,
  input  logic [3:0]        alu_ctrl_d,
  input  logic [1:0]        alu_src2_d,
  output logic              valid_e,
  output logic [ADDR_W-1:0] pc_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic              jal_e,
  output logic              jalr_e,
  output logic              mem_to_reg_e,
  output logic              load_npc_e,
  output logic              alu_src1_e,
  output logic [2:0]        reg_write_e,
  output logic [3:0]        mem_write_e,
  output logic [1:0]        reg_read_e,
  output logic [2:0]        branch_type_e,
  output logic [3:0]        alu_ctrl_e,
  output logic [1:0]        alu_src2_e,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic w_ex_is_load;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_bubble;
  logic w_capture;
  logic w_cnt_inc;

  // A load in EX writing x0 never produces a value worth waiting for.
  assign w_ex_is_load = valid_e & mem_to_reg_e & (|reg_write_e) & (|rd_e);
  assign w_hit_rs1    = reg_read_d[1] & (rs1_d == rd_e);
  assign w_hit_rs2    = reg_read_d[0] & (rs2_d == rd_e);

  assign load_use_stall = valid_d & ~flush & w_ex_is_load & (w_hit_rs1 | w_hit_rs2);

  // Flush wins even over a held pipeline; the hazard bubble only lands when en=1.
  assign w_bubble  = flush | (en & load_use_stall);
  assign w_capture = en & ~w_bubble;
  assign w_cnt_inc = en & load_use_stall & (bubble_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e       <= 1'b0;
      pc_e          <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
      jal_e         <= 1'b0;
      jalr_e        <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      load_npc_e    <= 1'b0;
      alu_src1_e    <= 1'b0;
      reg_write_e   <= '0;
      mem_write_e   <= '0;
      reg_read_e    <= '0;
      branch_type_e <= '0;
      alu_ctrl_e    <= '0;
      alu_src2_e    <= '0;
    end else if (w_bubble) begin
      valid_e       <= 1'b0;
      pc_e          <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
      jal_e         <= 1'b0;
      jalr_e        <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      load_npc_e    <= 1'b0;
      alu_src1_e    <= 1'b0;
      reg_write_e   <= '0;
      mem_write_e   <= '0;
      reg_read_e    <= '0;
      branch_type_e <= '0;
      alu_ctrl_e    <= '0;
      alu_src2_e    <= '0;
    end else if (w_capture) begin
      valid_e       <= valid_d;
      pc_e          <= pc_d;
      rs1_e         <= rs1_d;
      rs2_e         <= rs2_d;
      rd_e          <= rd_d;
      jal_e         <= jal_d;
      jalr_e        <= jalr_d;
      mem_to_reg_e  <= mem_to_reg_d;
      load_npc_e    <= load_npc_d;
      alu_src1_e    <= alu_src1_d;
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      reg_read_e    <= reg_read_d;
      branch_type_e <= branch_type_d;
      alu_ctrl_e    <= alu_ctrl_d;
      alu_src2_e    <= alu_src2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (w_cnt_inc) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_seg.sv
// Bench for id_ex_ctrl_seg: directed pipeline scenarios then randomized traffic against a slot-level model.
module tb_id_ex_ctrl_seg;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        jal;
    logic        jalr;
    logic        m2r;
    logic        lnpc;
    logic        src1;
    logic [2:0]  rw;
    logic [3:0]  mw;
    logic [1:0]  rr;
    logic [2:0]  bt;
    logic [3:0]  ac;
    logic [1:0]  src2;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic flush = 1'b0;
  slot_t din = '0;

  logic             valid_e, jal_e, jalr_e, mem_to_reg_e, load_npc_e, alu_src1_e;
  logic [31:0]      pc_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic [2:0]       reg_write_e, branch_type_e;
  logic [3:0]       mem_write_e, alu_ctrl_e;
  logic [1:0]       reg_read_e, alu_src2_e;
  logic             load_use_stall;
  logic [CNT_W-1:0] bubble_cnt;
  slot_t            ex_obs;

  assign ex_obs = {valid_e, pc_e, rs1_e, rs2_e, rd_e, jal_e, jalr_e, mem_to_reg_e,
                   load_npc_e, alu_src1_e, reg_write_e, mem_write_e, reg_read_e,
                   branch_type_e, alu_ctrl_e, alu_src2_e};

  id_ex_ctrl_seg #(.ADDR_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .valid_d(din.valid), .pc_d(din.pc), .rs1_d(din.rs1), .rs2_d(din.rs2), .rd_d(din.rd),
    .jal_d(din.jal), .jalr_d(din.jalr), .mem_to_reg_d(din.m2r), .load_npc_d(din.lnpc),
    .alu_src1_d(din.src1), .reg_write_d(din.rw), .mem_write_d(din.mw), .reg_read_d(din.rr),
    .branch_type_d(din.bt), .alu_ctrl_d(din.ac), .alu_src2_d(din.src2),
    .valid_e(valid_e), .pc_e(pc_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .jal_e(jal_e), .jalr_e(jalr_e), .mem_to_reg_e(mem_to_reg_e), .load_npc_e(load_npc_e),
    .alu_src1_e(alu_src1_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .reg_read_e(reg_read_e), .branch_type_e(branch_type_e), .alu_ctrl_e(alu_ctrl_e),
    .alu_src2_e(alu_src2_e), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  slot_t m_ex = '0;
  int    m_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The consumer must wait when EX holds a real load into a nonzero register it reads.
  function automatic logic m_stall();
    logic uses;
    uses = (din.rr[1] && din.rs1 == m_ex.rd) || (din.rr[0] && din.rs2 == m_ex.rd);
    return din.valid && m_ex.valid && !flush && m_ex.m2r && (m_ex.rw != 0)
           && (m_ex.rd != 0) && uses;
  endfunction

  task automatic tick(input string tag);
    logic exp_stall;
    #1;
    exp_stall = m_stall();
    chk({tag, ".stall"}, 128'(load_use_stall), 128'(exp_stall));
    @(posedge clk);
    if (flush) m_ex = '0;
    else if (!en) m_ex = m_ex;
    else if (exp_stall) begin
      m_ex = '0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else m_ex = din;
    #1;
    chk({tag, ".slot"}, 128'(ex_obs), 128'(m_ex));
    chk({tag, ".cnt"}, 128'(bubble_cnt), 128'(m_cnt));
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_ex  = '0;
    m_cnt = 0;
    chk({tag, ".slot"}, 128'(ex_obs), 128'(m_ex));
    chk({tag, ".cnt"}, 128'(bubble_cnt), 128'(m_cnt));
    chk({tag, ".stall"}, 128'(load_use_stall), 128'(0));
    rst_n = 1'b1;
    #1;
  endtask

  function automatic slot_t rnd_slot();
    slot_t s;
    s       = slot_t'({$urandom, $urandom, $urandom});
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom_range(0, 3));
    s.valid = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  function automatic slot_t mk_load(input logic [4:0] rd);
    slot_t s = '0;
    s.valid = 1'b1; s.pc = 32'h200; s.rs1 = 5'd2; s.rd = rd;
    s.m2r = 1'b1; s.rw = 3'b010; s.rr = 2'b10; s.ac = 4'h0; s.src2 = 2'b01;
    return s;
  endfunction

  function automatic slot_t mk_use(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] rr);
    slot_t s = '0;
    s.valid = 1'b1; s.pc = 32'h204; s.rs1 = rs1; s.rs2 = rs2; s.rd = 5'd6;
    s.rw = 3'b010; s.rr = rr; s.ac = 4'h1;
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state while random inputs toggle.
    din = rnd_slot();
    @(posedge clk); #1;
    chk("rst.slot", 128'(ex_obs), 128'(0));
    chk("rst.cnt", 128'(bubble_cnt), 128'(0));
    rst_n = 1'b1;

    // Normal flow.
    din = '0; din.valid = 1'b1; din.pc = 32'h100; din.ac = 4'h3; din.rd = 5'd7;
    tick("flow");
    chk("flow.pc", 128'(pc_e), 128'(32'h100));
    chk("flow.ac", 128'(alu_ctrl_e), 128'(4'h3));
    chk("flow.rd", 128'(rd_e), 128'(5'd7));
    chk("flow.valid", 128'(valid_e), 128'(1));

    // Load-use on x5: one bubble, then capture.
    din = mk_load(5'd5); tick("lu.load");
    din = mk_use(5'd5, 5'd1, 2'b11); #1;
    chk("lu.stall_hi", 128'(load_use_stall), 128'(1));
    tick("lu.bubble");
    chk("lu.valid_lo", 128'(valid_e), 128'(0));
    chk("lu.cnt1", 128'(bubble_cnt), 128'(1));
    tick("lu.capture");
    chk("lu.captured_pc", 128'(pc_e), 128'(32'h204));

    // Load to x0 never stalls.
    din = mk_load(5'd0); tick("x0.load");
    din = mk_use(5'd0, 5'd0, 2'b11); #1;
    chk("x0.stall_lo", 128'(load_use_stall), 128'(0));
    tick("x0.use");

    // rs2 matches but is unused.
    din = mk_load(5'd5); tick("unused.load");
    din = mk_use(5'd1, 5'd5, 2'b10); #1;
    chk("unused.stall_lo", 128'(load_use_stall), 128'(0));
    tick("unused.use");
    chk("unused.cnt", 128'(bubble_cnt), 128'(1));

    // Flush beats hold.
    en = 1'b0; flush = 1'b1; din = rnd_slot();
    tick("flush_hold");
    chk("flush_hold.valid", 128'(valid_e), 128'(0));
    en = 1'b1; flush = 1'b0;

    // Flush masks a hazard.
    din = mk_load(5'd5); tick("fl.load");
    din = mk_use(5'd5, 5'd5, 2'b11); flush = 1'b1; #1;
    chk("fl.stall_lo", 128'(load_use_stall), 128'(0));
    tick("fl.flush");
    flush = 1'b0;

    // Hold outranks the hazard; bubble lands once en returns.
    din = mk_load(5'd5); tick("hold.load");
    din = mk_use(5'd5, 5'd5, 2'b11); en = 1'b0;
    tick("hold.1"); tick("hold.2");
    en = 1'b1;
    tick("hold.release");
    chk("hold.cnt2", 128'(bubble_cnt), 128'(2));

    // Saturation after 20 hazards.
    for (int i = 0; i < 20; i++) begin
      din = mk_load(5'd5); tick("sat.load");
      din = mk_use(5'd3, 5'd5, 2'b01); tick("sat.use");
    end
    chk("sat.cnt15", 128'(bubble_cnt), 128'(15));
    do_reset("sat.rst");

    // Randomized traffic with occasional flush, hold and async reset.
    for (int i = 0; i < 400; i++) begin
      din   = rnd_slot();
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 11) == 0);
      if (din.valid && $urandom_range(0, 1) == 1) begin
        din.m2r = 1'b1;
        din.rw  = 3'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 59) == 0) do_reset("rnd.rst");
      else tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_seg.md
Name: id_ex_ctrl_seg

Overview:
- ID/EX segment register for the RV32 pipeline.
- Captures the instruction decoder's control outputs, plus PC and register indices, at each clock edge and presents them to EX.
- Contains load-use hazard detection: inserts a one-cycle bubble and asks IF/ID and PC to hold.
- Honours an external flush (branch/jalr redirect) and an external stall enable.
- Keeps a saturating count of load-use bubbles for performance debug.

Parameters:
- ADDR_W, 32, width of PC fields.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = register may update; 0 = hold (external stall, e.g. memory wait).
- flush  in  1  1 = load a bubble (redirect resolved in EX).
- valid_d  in  1  the ID slot holds a real instruction.
- pc_d  in  ADDR_W  PC of the ID instruction.
- rs1_d, rs2_d, rd_d  in  5 each  register indices from ID.
- jal_d, jalr_d, mem_to_reg_d, load_npc_d, alu_src1_d  in  1 each  decoder controls.
- reg_write_d  in  3  register write mode.
- mem_write_d  in  4  byte write enables.
- reg_read_d  in  2  bit1 = rs1 used, bit0 = rs2 used.
- branch_type_d  in  3  branch type.
- alu_ctrl_d  in  4  ALU operation.
- alu_src2_d  in  2  ALU operand-2 select.
- valid_e, pc_e, rs1_e, rs2_e, rd_e  out  registered copies of the corresponding _d inputs.
- jal_e, jalr_e, mem_to_reg_e, load_npc_e, alu_src1_e  out  1 each  registered controls.
- reg_write_e (3), mem_write_e (4), reg_read_e (2), branch_type_e (3), alu_ctrl_e (4), alu_src2_e (2)  out  registered controls.
- load_use_stall  out  1  combinational; 1 = IF/ID and PC must hold this cycle.
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output = 0, including valid_e and bubble_cnt. A zeroed slot is the canonical bubble. Reset mid-operation discards the EX contents immediately, without waiting for a clock edge.
- Hazard detection (combinational), load_use_stall = 1 only when all of these hold:
  - valid_d = 1, valid_e = 1 and flush = 0;
  - mem_to_reg_e = 1 and reg_write_e != 0;
  - rd_e != 0;
  - (reg_read_d[1] = 1 and rs1_d = rd_e) or (reg_read_d[0] = 1 and rs2_d = rd_e).
- Rising-edge update, evaluated in priority order (first match wins):
  1. flush=1: load bubble (all outputs 0, valid_e = 0). Applies even when en=0.
  2. en=0: hold all outputs.
  3. load_use_stall=1: load bubble; bubble_cnt increments by 1, saturating at 2^CNT_W-1.
  4. Otherwise: capture every _d input into its _e output.
- Flush bubbles and reset never change bubble_cnt except that reset clears it.
- Latency: 1 cycle from ID inputs to EX outputs.
- A load-use hazard costs exactly 1 bubble. The held ID instruction sees valid_e=0 on the next cycle, so the stall drops and the instruction is captured on the following edge.
- Back-to-back loads: lw x5 followed by lw x6,0(x5) produces one bubble; the second load then becomes valid_e and may stall its own consumer.
- en=0 while load_use_stall=1: hold takes precedence. No bubble and no count until en returns to 1 with the hazard still present.
- A hazard on both sources at once produces one bubble and counts 1.

Test Plan:
- Reset: drive random inputs, pulse rst_n low between edges -> all outputs read 0 immediately; bubble_cnt=0.
- Normal flow: valid_d=1, pc_d=0x100, alu_ctrl_d=4'h3, rd_d=7, en=1 -> after 1 edge pc_e=0x100, alu_ctrl_e=3, rd_e=7, valid_e=1; load_use_stall=0 throughout.
- Load-use: EX holds lw x5 (mem_to_reg_e=1, reg_write_e!=0, rd_e=5); ID holds add x6,x5,x1 with reg_read_d=2'b11 -> load_use_stall=1.
  - Next edge: valid_e=0, bubble_cnt=1.
  - Following edge: add captured, stall=0.
  - Same scenario with rd_e=0 -> no stall.
- Unused source: same load, ID instruction with rs2_d=5 but reg_read_d=2'b10 -> no stall, no count.
- Flush vs stall: en=0 and flush=1 at the same edge -> bubble loaded. Hazard present and flush=1 -> load_use_stall=0 and bubble_cnt unchanged.
- Saturation: CNT_W=4, 20 consecutive load-use hazards -> bubble_cnt stops at 15. Then rst_n pulse -> 0.
